data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Data-memory controller directly downstream of the MEM stage. Accepts one load/store request
//   (mem_re/mem_we, word address, write data) and performs it on an internal single-port word RAM
//   after a configurable number of wait states. Holds the pipeline with stall_o until the access
//   completes, then returns load data on mem_rdata with a one-cycle mem_ready pulse.
// PARAMETERS
//   DATA_W       32  data word width
//   ADDR_W       10  word-address width; RAM depth = 2**ADDR_W words
//   WAIT_CYCLES  2   wait states per access, legal range 0..15
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   mem_re     in   1       load request from MEM stage
//   mem_we     in   1       store request from MEM stage
//   mem_addr   in   ADDR_W  word address of the access
//   mem_wdata  in   DATA_W  store data
//   mem_rdata  out  DATA_W  load data, registered; holds until the next load completes
//   mem_ready  out  1       one-cycle pulse in the DONE cycle of every access
//   stall_o    out  1       pipeline hold request, active high
//   err_o      out  1       sticky flag: mem_re and mem_we were both high at acceptance
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state<=IDLE, wait counter<=0, mem_rdata<=0, mem_ready<=0,
//     err_o<=0, captured addr/data/op<=0. RAM contents are NOT cleared.
//   - FSM states: IDLE, WAIT, DONE.
//   - IDLE: a request is present when (mem_re|mem_we)=1. stall_o is driven combinationally high
//     in that same cycle T. At the edge ending T: capture mem_addr, mem_wdata and op
//     (write wins if both are high; err_o<=1 in that case). Load counter<=WAIT_CYCLES.
//     Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
//   - WAIT: stall_o=1. Counter decrements by 1 each cycle. When counter==1 at an edge: commit
//     the access and go to DONE. Commit = RAM[addr]<=wdata for a store, mem_rdata<=RAM[addr]
//     for a load. With WAIT_CYCLES=0 the commit happens on the edge leaving IDLE.
//   - DONE: occurs in cycle T+1+WAIT_CYCLES. In this cycle stall_o=0 and mem_ready=1, so the
//     pipeline advances past the access. The MEM-stage request is still visible in DONE; it
//     belongs to the completed access and is ignored. Next state is always IDLE.
//   - mem_ready is high only in DONE. mem_rdata changes only on a load commit; stores and
//     reset-free idle cycles leave it unchanged.
//   - Latency: T+1+WAIT_CYCLES from acceptance to DONE. Back-to-back requests therefore cost
//     2+WAIT_CYCLES cycles each (the IDLE acceptance cycle plus the DONE cycle).
//   - Inputs are sampled only in IDLE. Changes to mem_addr or mem_wdata during WAIT or DONE have
//     no effect.
//   - Reset during WAIT: the access is aborted, no RAM write and no mem_rdata update occur,
//     state returns to IDLE.
//   - Reset during DONE: the commit has already happened; only the outputs are reset.
//   - err_o is cleared only by rst.
//   - Address wrap: all 2**ADDR_W words are valid, so there is no out-of-range case.
//   - Read-after-write to the same address in consecutive accesses returns the new data.
// TESTING
//   1. Assert rst for 2 cycles -> mem_rdata=0, mem_ready=0, stall_o=0, err_o=0, state IDLE.
//   2. WAIT_CYCLES=2; store 0xDEADBEEF to addr 5 accepted at cycle T -> stall_o=1 at T, T+1, T+2;
//      at T+3 mem_ready=1 and stall_o=0; mem_rdata unchanged.
//   3. Load from addr 5 -> mem_rdata=0xDEADBEEF and mem_ready=1 at DONE; value held for 10 idle
//      cycles.
//   4. Store 0x1 to addr 1023, then load from addr 1023 held back-to-back -> load returns 0x1;
//      each access spans 4 cycles; the held request in DONE is not re-executed.
//   5. mem_re=mem_we=1, addr 7, wdata 0xA5A5A5A5 -> store executes, mem_rdata unchanged,
//      err_o=1 and stays 1 until rst.
//   6. Store 0x55 to addr 3 with rst pulsed during WAIT -> a later load of addr 3 returns the
//      prior contents.
//   7. WAIT_CYCLES=0 -> DONE at T+1.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the MEM stage: one load/store at a time on an internal
// single-port word RAM, with a fixed number of wait states and a pipeline stall while busy.
module data_mem_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;

    logic              cap_c;
    logic              commit_c;
    logic              commit_we_c;
    logic [ADDR_W-1:0] commit_addr_c;
    logic [DATA_W-1:0] commit_wdata_c;

    logic [DATA_W-1:0] ram [DEPTH];

    // Next state, commit selection and the combinational stall.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cap_c          = 1'b0;
        commit_c       = 1'b0;
        commit_we_c    = we_q;
        commit_addr_c  = addr_q;
        commit_wdata_c = wdata_q;
        stall_o        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_re || mem_we) begin
                    stall_o = 1'b1;
                    cap_c   = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: commit straight from the live request.
                        state_d        = ST_DONE;
                        commit_c       = 1'b1;
                        commit_we_c    = mem_we;
                        commit_addr_c  = mem_addr;
                        commit_wdata_c = mem_wdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    commit_c = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, captured request, load data and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_DONE);
            if (cap_c) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                we_q    <= mem_we;
                if (mem_re && mem_we) begin
                    err_q <= 1'b1;
                end
            end
            if (commit_c && !commit_we_c) begin
                rdata_q <= ram[commit_addr_c];
            end
        end
    end

    // RAM array is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit_c && commit_we_c) begin
            ram[commit_addr_c] <= commit_wdata_c;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: one instance with 2 wait states, one with none,
// both checked against an array-based memory model and per-access cycle timing.
module tb_data_mem_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    logic              clk;
    logic              rst   [2];
    logic              re    [2];
    logic              we    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] rdata [2];
    logic              ready [2];
    logic              stall [2];
    logic              err   [2];

    logic [DATA_W-1:0] model_mem   [2][DEPTH];
    bit                model_valid [2][DEPTH];
    logic [DATA_W-1:0] exp_rd  [2];
    logic              exp_err [2];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst[0]), .mem_re(re[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
        .stall_o(stall[0]), .err_o(err[0])
    );

    data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst[1]), .mem_re(re[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
        .stall_o(stall[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_states(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // Idle cycles: no request, outputs quiet, load data held.
    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            re[s] = 1'b0;
            we[s] = 1'b0;
            #1;
            check_eq("idle_stall", 32'(stall[s]), 0);
            check_eq("idle_ready", 32'(ready[s]), 0);
            check_eq("idle_rdata", rdata[s], exp_rd[s]);
            check_eq("idle_err", 32'(err[s]), 32'(exp_err[s]));
        end
    endtask

    task automatic do_reset(input int s, input int n);
        @(negedge clk);
        re[s]  = 1'b0;
        we[s]  = 1'b0;
        rst[s] = 1'b1;
        repeat (n) @(negedge clk);
        rst[s] = 1'b0;
        exp_rd[s]  = '0;
        exp_err[s] = 1'b0;
        #1;
        check_eq("rst_rdata", rdata[s], 0);
        check_eq("rst_ready", 32'(ready[s]), 0);
        check_eq("rst_stall", 32'(stall[s]), 0);
        check_eq("rst_err", 32'(err[s]), 0);
    endtask

    // One access: accept cycle, wait cycles with scrambled inputs, then the DONE cycle.
    // The request stays asserted through DONE, as a stalled MEM stage would leave it.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int wc;
        wc = wait_states(s);
        @(negedge clk);
        re[s]    = r;
        we[s]    = w;
        addr[s]  = a;
        wdata[s] = d;
        #1;
        check_eq("accept_stall", 32'(stall[s]), 1);
        check_eq("accept_ready", 32'(ready[s]), 0);
        for (int k = 0; k < wc; k++) begin
            @(negedge clk);
            addr[s]  = ADDR_W'($urandom);
            wdata[s] = $urandom;
            #1;
            check_eq("wait_stall", 32'(stall[s]), 1);
            check_eq("wait_ready", 32'(ready[s]), 0);
        end
        @(negedge clk);
        #1;
        if (w) begin
            model_mem[s][a]   = d;
            model_valid[s][a] = 1'b1;
        end else if (r) begin
            exp_rd[s] = model_mem[s][a];
        end
        if (r && w) exp_err[s] = 1'b1;
        check_eq("done_stall", 32'(stall[s]), 0);
        check_eq("done_ready", 32'(ready[s]), 1);
        check_eq("done_rdata", rdata[s], exp_rd[s]);
        check_eq("done_err", 32'(err[s]), 32'(exp_err[s]));
    endtask

    // Store whose commit edge coincides with reset: must leave RAM untouched.
    task automatic aborted_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        re[0] = 1'b0; we[0] = 1'b1; addr[0] = a; wdata[0] = d;
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        re[0]  = 1'b0;
        we[0]  = 1'b0;
        exp_rd[0]  = '0;
        exp_err[0] = 1'b0;
        #1;
        check_eq("abort_stall", 32'(stall[0]), 0);
        check_eq("abort_ready", 32'(ready[0]), 0);
        check_eq("abort_rdata", rdata[0], 0);
        check_eq("abort_err", 32'(err[0]), 0);
    endtask

    task automatic random_run(input int s, input int n);
        logic [ADDR_W-1:0] a;
        int op;
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 5));
            a  = ADDR_W'($urandom_range(0, 63));
            if (op <= 2 && model_valid[s][a]) begin
                access(s, 1'b1, 1'b0, a, $urandom);
            end else if (op == 5) begin
                access(s, 1'b1, 1'b1, a, $urandom);
            end else begin
                access(s, 1'b0, 1'b1, a, $urandom);
            end
            if ($urandom_range(0, 3) == 0) idle(s, int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; re[s] = 1'b0; we[s] = 1'b0;
            addr[s] = '0; wdata[s] = '0;
            exp_rd[s] = '0; exp_err[s] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[s][i]   = '0;
                model_valid[s][i] = 1'b0;
            end
        end

        do_reset(0, 2);
        do_reset(1, 2);

        access(0, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);
        idle(0, 1);
        access(0, 1'b1, 1'b0, 10'd5, 32'h0);
        idle(0, 10);

        access(0, 1'b0, 1'b1, 10'd1023, 32'h1);
        access(0, 1'b1, 1'b0, 10'd1023, 32'h0);
        idle(0, 2);

        access(0, 1'b1, 1'b1, 10'd7, 32'hA5A5_A5A5);
        idle(0, 3);
        access(0, 1'b1, 1'b0, 10'd7, 32'h0);
        idle(0, 2);

        access(0, 1'b0, 1'b1, 10'd3, 32'h1122_3344);
        idle(0, 1);
        aborted_store(10'd3, 32'h55);
        access(0, 1'b1, 1'b0, 10'd3, 32'h0);
        idle(0, 1);

        random_run(0, 150);

        access(1, 1'b0, 1'b1, 10'd9, 32'hCAFE_F00D);
        access(1, 1'b1, 1'b0, 10'd9, 32'h0);
        idle(1, 2);
        random_run(1, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
